// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the fetch/data bus arbiter: ownership states and bus size codes.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_I = 2'd1,
      ST_OWN_D = 2'd2
   } arbState_t;

   localparam logic [2:0] SIZE_BYTE = 3'b001;
   localparam logic [2:0] SIZE_HALF = 3'b010;
   localparam logic [2:0] SIZE_WORD = 3'b100;

endpackage

// File: rtl/bus_arbiter.sv
// Two-port arbiter sharing one memory bus between instruction fetch and the Memory stage,
// with combinational grant, beat ownership under rw_wait, d_lock bursts and fetch starvation relief.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_busaddr,
   input  logic        i_rd_req,
   output logic        i_wait,
   output logic [31:0] i_rd_data,
   input  logic [31:0] d_busaddr,
   input  logic        d_rd_req,
   input  logic        d_wr_req,
   input  logic [31:0] d_wr_data,
   input  logic [2:0]  d_data_size,
   input  logic        d_lock,
   output logic        d_wait,
   output logic [31:0] d_rd_data,
   output logic [31:0] busaddr,
   output logic        rd_req,
   output logic        wr_req,
   output logic [31:0] wr_data,
   output logic [2:0]  data_size,
   input  logic        rw_wait,
   input  logic [31:0] rd_data,
   output logic        gnt_i,
   output logic        gnt_d
);

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arbState_t        r_state;
   arbState_t        w_nextState;
   logic [CNT_W-1:0] r_starveCnt;
   logic             w_dReq;
   logic             w_arbitrate;
   logic             w_grantI;
   logic             w_grantD;
   logic             w_lockHold;

   assign w_dReq = d_rd_req | d_wr_req;

   // Grant and next-state: an owner with its request still up keeps the bus, an abandoned
   // ownership falls through to fresh arbitration in the same cycle, and a locked data owner
   // with no request parks the bus so fetch cannot slip in between burst beats.
   always_comb begin
      w_arbitrate = 1'b0;
      w_grantI    = 1'b0;
      w_grantD    = 1'b0;
      w_lockHold  = 1'b0;
      w_nextState = ST_IDLE;
      if (!rst) begin
         unique case (r_state)
            ST_OWN_I: begin
               if (i_rd_req) w_grantI = 1'b1;
               else          w_arbitrate = 1'b1;
            end
            ST_OWN_D: begin
               if (w_dReq)       w_grantD = 1'b1;
               else if (d_lock)  w_lockHold = 1'b1;
               else              w_arbitrate = 1'b1;
            end
            default: w_arbitrate = 1'b1;
         endcase

         if (w_arbitrate) begin
            if (w_dReq && (!i_rd_req || (r_starveCnt != CNT_MAX))) w_grantD = 1'b1;
            else if (i_rd_req)                                     w_grantI = 1'b1;
         end

         if (w_grantI)                       w_nextState = rw_wait ? ST_OWN_I : ST_IDLE;
         else if (w_grantD)                  w_nextState = (rw_wait || d_lock) ? ST_OWN_D : ST_IDLE;
         else if (w_lockHold)                w_nextState = ST_OWN_D;
         else                                w_nextState = ST_IDLE;
      end
   end

   // Bus mux and per-port stalls; fetch is always a word read.
   always_comb begin
      busaddr   = 32'd0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      wr_data   = 32'd0;
      data_size = 3'b000;
      if (w_grantD) begin
         busaddr   = d_busaddr;
         rd_req    = d_rd_req;
         wr_req    = d_wr_req;
         wr_data   = d_wr_data;
         data_size = d_data_size;
      end else if (w_grantI) begin
         busaddr   = i_busaddr;
         rd_req    = 1'b1;
         data_size = SIZE_WORD;
      end
   end

   assign gnt_i     = w_grantI;
   assign gnt_d     = w_grantD;
   assign i_wait    = w_grantI ? rw_wait : 1'b1;
   assign d_wait    = w_grantD ? rw_wait : 1'b1;
   assign i_rd_data = rd_data;
   assign d_rd_data = rd_data;

   // Starvation counter tracks completed data beats taken while fetch is waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_starveCnt <= '0;
      end else begin
         r_state <= w_nextState;
         if (!i_rd_req || (w_grantI && !rw_wait)) begin
            r_starveCnt <= '0;
         end else if (w_grantD && !rw_wait && (r_starveCnt != CNT_MAX)) begin
            r_starveCnt <= r_starveCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table-driven cycle vectors with a scoreboard queue,
// plus a hand-written reset-during-lock sequence.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int         STARVE_LIMIT = 4;
   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_I    = 2'd1;
   localparam logic [1:0] G_D    = 2'd2;

   typedef struct {
      string      tag;
      logic       rst;
      logic       iReq;
      logic       dRd;
      logic       dWr;
      logic       dLock;
      logic       rwWait;
      logic [1:0] expGnt;
   } vec_t;

   typedef struct {
      string       tag;
      logic        gntI;
      logic        gntD;
      logic        iWait;
      logic        dWait;
      logic        rdReq;
      logic        wrReq;
      logic [31:0] addr;
      logic [31:0] wrData;
      logic [2:0]  size;
      logic [31:0] rdData;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_busaddr;
   logic        i_rd_req;
   logic        i_wait;
   logic [31:0] i_rd_data;
   logic [31:0] d_busaddr;
   logic        d_rd_req;
   logic        d_wr_req;
   logic [31:0] d_wr_data;
   logic [2:0]  d_data_size;
   logic        d_lock;
   logic        d_wait;
   logic [31:0] d_rd_data;
   logic [31:0] busaddr;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] wr_data;
   logic [2:0]  data_size;
   logic        rw_wait;
   logic [31:0] rd_data;
   logic        gnt_i;
   logic        gnt_d;

   vec_t vecs[$];
   exp_t sb[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   stepIdx     = 0;
   logic [2:0] sizeTab [3];

   bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_busaddr(i_busaddr), .i_rd_req(i_rd_req), .i_wait(i_wait), .i_rd_data(i_rd_data),
      .d_busaddr(d_busaddr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_wr_data(d_wr_data),
      .d_data_size(d_data_size), .d_lock(d_lock), .d_wait(d_wait), .d_rd_data(d_rd_data),
      .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
      .data_size(data_size), .rw_wait(rw_wait), .rd_data(rd_data),
      .gnt_i(gnt_i), .gnt_d(gnt_d)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(string tag, logic r, logic iReq, logic dRd, logic dWr,
                                  logic dLock, logic rwWait, logic [1:0] g);
      vec_t v;
      v.tag = tag; v.rst = r; v.iReq = iReq; v.dRd = dRd; v.dWr = dWr;
      v.dLock = dLock; v.rwWait = rwWait; v.expGnt = g;
      return v;
   endfunction

   task automatic addVec(string tag, logic r, logic iReq, logic dRd, logic dWr,
                         logic dLock, logic rwWait, logic [1:0] g);
      vecs.push_back(mkVec(tag, r, iReq, dRd, dWr, dLock, rwWait, g));
   endtask

   task automatic compareField(string tag, string field, logic [31:0] act, logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge and queue what the outputs must be.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = v.rst;
      i_rd_req    = v.iReq;
      i_busaddr   = 32'h0000_1000 + 32'(stepIdx * 4);
      d_rd_req    = v.dRd;
      d_wr_req    = v.dWr;
      d_lock      = v.dLock;
      d_busaddr   = 32'h8000_0000 | 32'(stepIdx * 8);
      d_wr_data   = 32'hA5A5_0000 | 32'(stepIdx);
      d_data_size = sizeTab[stepIdx % 3];
      rw_wait     = v.rwWait;
      rd_data     = $urandom;

      e.tag    = $sformatf("%s#%0d", v.tag, stepIdx);
      e.gntI   = (v.expGnt == G_I);
      e.gntD   = (v.expGnt == G_D);
      e.iWait  = e.gntI ? v.rwWait : 1'b1;
      e.dWait  = e.gntD ? v.rwWait : 1'b1;
      e.rdData = rd_data;
      if (e.gntI) begin
         e.addr = i_busaddr; e.rdReq = 1'b1; e.wrReq = 1'b0; e.wrData = 32'd0; e.size = SIZE_WORD;
      end else if (e.gntD) begin
         e.addr = d_busaddr; e.rdReq = v.dRd; e.wrReq = v.dWr; e.wrData = d_wr_data; e.size = d_data_size;
      end else begin
         e.addr = 32'd0; e.rdReq = 1'b0; e.wrReq = 1'b0; e.wrData = 32'd0; e.size = 3'b000;
      end
      sb.push_back(e);
      stepIdx++;
   endtask

   // Sample the combinational outputs mid-cycle against the oldest queued expectation.
   task automatic checkOutput();
      exp_t e;
      @(negedge clk);
      testsRun++;
      if (sb.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         testsRun--;
         e = sb.pop_front();
         compareField(e.tag, "gnt_i",     32'(gnt_i),     32'(e.gntI));
         compareField(e.tag, "gnt_d",     32'(gnt_d),     32'(e.gntD));
         compareField(e.tag, "i_wait",    32'(i_wait),    32'(e.iWait));
         compareField(e.tag, "d_wait",    32'(d_wait),    32'(e.dWait));
         compareField(e.tag, "rd_req",    32'(rd_req),    32'(e.rdReq));
         compareField(e.tag, "wr_req",    32'(wr_req),    32'(e.wrReq));
         compareField(e.tag, "busaddr",   busaddr,        e.addr);
         compareField(e.tag, "wr_data",   wr_data,        e.wrData);
         compareField(e.tag, "data_size", 32'(data_size), 32'(e.size));
         compareField(e.tag, "i_rd_data", i_rd_data,      e.rdData);
         compareField(e.tag, "d_rd_data", d_rd_data,      e.rdData);
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   initial begin
      sizeTab[0] = SIZE_BYTE; sizeTab[1] = SIZE_HALF; sizeTab[2] = SIZE_WORD;
      rst = 1'b1; i_rd_req = 1'b0; i_busaddr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
      d_lock = 1'b0; d_busaddr = '0; d_wr_data = '0; d_data_size = '0; rw_wait = 1'b0; rd_data = '0;

      //      tag       rst iReq dRd dWr lock wait grant
      addVec("reset",    1, 1,   1,  0,  0,   0,   G_NONE);
      addVec("reset",    1, 0,   1,  1,  1,   1,   G_NONE);
      addVec("both",     0, 1,   1,  0,  0,   0,   G_D);
      addVec("fetchNxt", 0, 1,   0,  0,  0,   0,   G_I);
      addVec("dWrOnly",  0, 0,   0,  1,  0,   0,   G_D);
      addVec("none",     0, 0,   0,  0,  0,   0,   G_NONE);
      addVec("iOnly",    0, 1,   0,  0,  0,   0,   G_I);

      addVec("reset",    1, 0,   0,  0,  0,   0,   G_NONE);
      addVec("dWait1",   0, 0,   1,  0,  0,   1,   G_D);
      addVec("dWait2",   0, 1,   1,  0,  0,   1,   G_D);
      addVec("dWait3",   0, 1,   1,  0,  0,   1,   G_D);
      addVec("dDone",    0, 1,   1,  0,  0,   0,   G_D);
      addVec("iAfterD",  0, 1,   0,  0,  0,   0,   G_I);
      addVec("iWait",    0, 1,   0,  0,  0,   1,   G_I);
      addVec("iKeeps",   0, 1,   1,  0,  0,   1,   G_I);
      addVec("iAbandon", 0, 0,   1,  0,  0,   1,   G_D);
      addVec("dFinish",  0, 0,   1,  0,  0,   0,   G_D);

      addVec("reset",    1, 0,   0,  0,  0,   0,   G_NONE);
      for (int k = 0; k < 2; k++) begin
         for (int b = 0; b < STARVE_LIMIT; b++) addVec("starveD", 0, 1, 1, 0, 0, 0, G_D);
         addVec("starveI", 0, 1, 1, 0, 0, 0, G_I);
      end

      addVec("reset",    1, 0,   0,  0,  0,   0,   G_NONE);
      for (int b = 0; b < 4; b++) addVec("ldm", 0, 1, 1, 0, 1, 0, G_D);
      addVec("lockGap",  0, 1,   0,  0,  1,   0,   G_NONE);
      addVec("ldmWait",  0, 1,   1,  0,  1,   1,   G_D);
      for (int b = 0; b < 3; b++) addVec("ldm", 0, 1, 1, 0, 1, 0, G_D);
      addVec("ldmLast",  0, 1,   1,  0,  0,   0,   G_D);
      addVec("iPostLck", 0, 1,   1,  0,  0,   0,   G_I);

      foreach (vecs[n]) runVec(vecs[n]);

      // Reset landing in the middle of a locked data burst must drop ownership entirely.
      runVec(mkVec("reset",    1, 0, 0, 0, 0, 0, G_NONE));
      runVec(mkVec("lockBeat", 0, 1, 1, 0, 1, 1, G_D));
      runVec(mkVec("lockDone", 0, 1, 1, 0, 1, 0, G_D));
      runVec(mkVec("rstLock",  1, 1, 1, 0, 1, 0, G_NONE));
      runVec(mkVec("freshI",   0, 1, 0, 0, 1, 0, G_I));
      runVec(mkVec("freshD",   0, 1, 1, 0, 0, 0, G_D));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
